// File: rtl/rbcp_reg_slave.sv
// ----------------------------------------------------------------------------
// rbcp_reg_slave
//
// RBCP (SiTCP register-access bus) responder living in the sys_clk domain.
// It decodes a 16-byte window starting at BASE_ADDR and answers every mapped
// access with a single-cycle rbcp_ack one cycle after the strobe. On read acks
// the read data is driven on rbcp_rd. On write acks, and whenever no ack is
// pending, rbcp_rd is 0.
//
// Register map (offset = rbcp_addr[3:0]):
//   0x0 ID       RO  ID_VALUE
//   0x1 VERSION  RO  VERSION
//   0x2 CTRL     RW  drives ctrl_out
//   0x3 PULSE    WO  pulse_out = write data for one cycle; reads 0
//   0x4 STAT0    RO  live status_in[7:0]; the read also snapshots [31:8]
//   0x5-0x7      RO  snapshot bytes [15:8], [23:16], [31:24]
//   0x8-0xA      RW  config shadow bytes [7:0], [15:8], [23:16]
//   0xB CFG3     RW  shadow[31:24]; a write commits the whole shadow to cfg_out
//   0xC-0xD      RO  write counter low/high byte (RBCP_WR_COUNTER_EN only);
//                    any write to either clears the counter
//   0xE-0xF      unmapped
//
// Optional feature macro: RBCP_WR_COUNTER_EN
//   When this macro is defined, a saturating 16-bit counter of acked writes is
//   built and exposed at 0xC/0xD. When it is undefined, those offsets are
//   unmapped and receive no ack.
//
// Ports:
//   sys_clk    in   1   system clock, rising edge
//   sys_rst    in   1   synchronous active-high reset
//   rbcp_act   in   1   transaction active
//   rbcp_addr  in   32  access address
//   rbcp_wd    in   8   write data
//   rbcp_we    in   1   write strobe (one cycle)
//   rbcp_re    in   1   read strobe (one cycle)
//   rbcp_ack   out  1   acknowledge (one cycle)
//   rbcp_rd    out  8   read data, valid only while rbcp_ack=1
//   status_in  in   32  live status word
//   ctrl_out   out  8   control register
//   pulse_out  out  8   self-clearing strobes
//   cfg_out    out  32  committed configuration word
// ----------------------------------------------------------------------------
module rbcp_reg_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  ID_VALUE  = 8'hA5,
  parameter logic [7:0]  VERSION   = 8'h01,
  parameter logic [7:0]  CTRL_INIT = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rbcp_act,
  input  logic [31:0] rbcp_addr,
  input  logic [7:0]  rbcp_wd,
  input  logic        rbcp_we,
  input  logic        rbcp_re,
  output logic        rbcp_ack,
  output logic [7:0]  rbcp_rd,
  input  logic [31:0] status_in,
  output logic [7:0]  ctrl_out,
  output logic [7:0]  pulse_out,
  output logic [31:0] cfg_out
);

  // Register offsets within the window
  localparam logic [3:0] OFF_ID    = 4'h0;
  localparam logic [3:0] OFF_VER   = 4'h1;
  localparam logic [3:0] OFF_CTRL  = 4'h2;
  localparam logic [3:0] OFF_PULSE = 4'h3;
  localparam logic [3:0] OFF_STAT0 = 4'h4;
  localparam logic [3:0] OFF_STAT1 = 4'h5;
  localparam logic [3:0] OFF_STAT2 = 4'h6;
  localparam logic [3:0] OFF_STAT3 = 4'h7;
  localparam logic [3:0] OFF_CFG0  = 4'h8;
  localparam logic [3:0] OFF_CFG1  = 4'h9;
  localparam logic [3:0] OFF_CFG2  = 4'hA;
  localparam logic [3:0] OFF_CFG3  = 4'hB;
`ifdef RBCP_WR_COUNTER_EN
  localparam logic [3:0] OFF_CNTL  = 4'hC;
  localparam logic [3:0] OFF_CNTH  = 4'hD;
`endif

  // State registers and their next-state values
  logic        ack_q,      ack_d;
  logic [7:0]  rd_q,       rd_d;
  logic [7:0]  ctrl_q,     ctrl_d;
  logic [7:0]  pulse_q,    pulse_d;
  logic [23:0] snapshot_q, snapshot_d;
  logic [31:0] shadow_q,   shadow_d;
  logic [31:0] cfg_q,      cfg_d;
`ifdef RBCP_WR_COUNTER_EN
  logic [15:0] wrCount_q,  wrCount_d;
`endif

  // Decode helpers
  logic [3:0] offset;
  logic       inWindow;
  logic       mapped;
  logic       hit;
  logic       wrHit;
  logic       rdHit;
  logic [7:0] readMux;

  assign offset   = rbcp_addr[3:0];
  assign inWindow = rbcp_act && (rbcp_addr[31:4] == BASE_ADDR[31:4]);
  assign hit      = inWindow && mapped;
  // A simultaneous read and write strobe is served as a write only, so reads
  // with side effects (STAT0 snapshot) cannot fire together with a write.
  assign wrHit    = hit && rbcp_we;
  assign rdHit    = hit && rbcp_re && !rbcp_we;

  // Which offsets answer at all; everything else is left to time out
  always_comb begin
    mapped = 1'b0;
    case (offset)
      OFF_ID, OFF_VER, OFF_CTRL, OFF_PULSE,
      OFF_STAT0, OFF_STAT1, OFF_STAT2, OFF_STAT3,
      OFF_CFG0, OFF_CFG1, OFF_CFG2, OFF_CFG3: mapped = 1'b1;
`ifdef RBCP_WR_COUNTER_EN
      OFF_CNTL, OFF_CNTH:                     mapped = 1'b1;
`endif
      default:                                mapped = 1'b0;
    endcase
  end

  // Read data selection. STAT0 returns the live status byte so that the low
  // byte and the snapshotted upper bytes come from the same sampling edge.
  always_comb begin
    readMux = 8'h00;
    case (offset)
      OFF_ID:    readMux = ID_VALUE;
      OFF_VER:   readMux = VERSION;
      OFF_CTRL:  readMux = ctrl_q;
      OFF_PULSE: readMux = 8'h00;
      OFF_STAT0: readMux = status_in[7:0];
      OFF_STAT1: readMux = snapshot_q[7:0];
      OFF_STAT2: readMux = snapshot_q[15:8];
      OFF_STAT3: readMux = snapshot_q[23:16];
      OFF_CFG0:  readMux = shadow_q[7:0];
      OFF_CFG1:  readMux = shadow_q[15:8];
      OFF_CFG2:  readMux = shadow_q[23:16];
      OFF_CFG3:  readMux = shadow_q[31:24];
`ifdef RBCP_WR_COUNTER_EN
      OFF_CNTL:  readMux = wrCount_q[7:0];
      OFF_CNTH:  readMux = wrCount_q[15:8];
`endif
      default:   readMux = 8'h00;
    endcase
  end

  // Next-state logic for the ack path and all registers
  always_comb begin
    ack_d      = wrHit || rdHit;
    rd_d       = rdHit ? readMux : 8'h00;
    ctrl_d     = ctrl_q;
    pulse_d    = 8'h00;
    snapshot_d = snapshot_q;
    shadow_d   = shadow_q;
    cfg_d      = cfg_q;

    if (wrHit) begin
      case (offset)
        OFF_CTRL:  ctrl_d           = rbcp_wd;
        OFF_PULSE: pulse_d          = rbcp_wd;
        OFF_CFG0:  shadow_d[7:0]    = rbcp_wd;
        OFF_CFG1:  shadow_d[15:8]   = rbcp_wd;
        OFF_CFG2:  shadow_d[23:16]  = rbcp_wd;
        OFF_CFG3: begin
          shadow_d[31:24] = rbcp_wd;
          // The top byte comes straight from the bus so the committed word
          // includes it on the same edge.
          cfg_d = {rbcp_wd, shadow_q[23:0]};
        end
        default: ;
      endcase
    end

    if (rdHit && (offset == OFF_STAT0)) begin
      snapshot_d = status_in[31:8];
    end
  end

`ifdef RBCP_WR_COUNTER_EN
  // Saturating count of acked writes; a write to either counter byte clears
  // it and is itself not counted.
  always_comb begin
    wrCount_d = wrCount_q;
    if (wrHit) begin
      if ((offset == OFF_CNTL) || (offset == OFF_CNTH)) begin
        wrCount_d = 16'h0000;
      end else if (wrCount_q != 16'hFFFF) begin
        wrCount_d = wrCount_q + 16'd1;
      end
    end
  end
`endif

  // State register; reset also discards any strobe seen on the same edge
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ack_q      <= 1'b0;
      rd_q       <= 8'h00;
      ctrl_q     <= CTRL_INIT;
      pulse_q    <= 8'h00;
      snapshot_q <= 24'h000000;
      shadow_q   <= 32'h0000_0000;
      cfg_q      <= 32'h0000_0000;
`ifdef RBCP_WR_COUNTER_EN
      wrCount_q  <= 16'h0000;
`endif
    end else begin
      ack_q      <= ack_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      pulse_q    <= pulse_d;
      snapshot_q <= snapshot_d;
      shadow_q   <= shadow_d;
      cfg_q      <= cfg_d;
`ifdef RBCP_WR_COUNTER_EN
      wrCount_q  <= wrCount_d;
`endif
    end
  end

  assign rbcp_ack  = ack_q;
  assign rbcp_rd   = rd_q;
  assign ctrl_out  = ctrl_q;
  assign pulse_out = pulse_q;
  assign cfg_out   = cfg_q;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_rbcp_reg_slave
//
// Directed bench for rbcp_reg_slave. Each access pushes its expected read
// data onto a scoreboard queue when the strobe is driven. A monitor pops the
// queue on every ack and checks that rbcp_rd is 0 in all other cycles.
// Register side effects (ctrl_out, pulse_out, cfg_out) are checked inline by
// the stimulus sequence.
// ----------------------------------------------------------------------------
module tb_rbcp_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_1230;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        rbcp_act;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd;
  logic        rbcp_we;
  logic        rbcp_re;
  logic        rbcp_ack;
  logic [7:0]  rbcp_rd;
  logic [31:0] status_in;
  logic [7:0]  ctrl_out;
  logic [7:0]  pulse_out;
  logic [31:0] cfg_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];
  logic monEn = 1'b0;

  rbcp_reg_slave #(
    .BASE_ADDR(BASE),
    .ID_VALUE (8'hA5),
    .VERSION  (8'h01),
    .CTRL_INIT(8'h00)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rbcp_act (rbcp_act),
    .rbcp_addr(rbcp_addr),
    .rbcp_wd  (rbcp_wd),
    .rbcp_we  (rbcp_we),
    .rbcp_re  (rbcp_re),
    .rbcp_ack (rbcp_ack),
    .rbcp_rd  (rbcp_rd),
    .status_in(status_in),
    .ctrl_out (ctrl_out),
    .pulse_out(pulse_out),
    .cfg_out  (cfg_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access: strobe for a single cycle, then confirm the scoreboard drained
  task automatic applyStimulus(input logic act, input logic [31:0] addr, input logic [7:0] wd,
                               input logic we, input logic re, input logic expectAck,
                               input logic [7:0] expRd);
    @(negedge sys_clk);
    rbcp_act  = act;
    rbcp_addr = addr;
    rbcp_wd   = wd;
    rbcp_we   = we;
    rbcp_re   = re;
    if (expectAck) expQ.push_back(expRd);
    @(negedge sys_clk);
    rbcp_act = 1'b0;
    rbcp_we  = 1'b0;
    rbcp_re  = 1'b0;
    #1;
    checkOutput("ackPending", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    applyStimulus(1'b1, BASE + {28'h0, off}, d, 1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic rd(input logic [3:0] off, input logic [7:0] exp);
    applyStimulus(1'b1, BASE + {28'h0, off}, 8'h00, 1'b0, 1'b1, 1'b1, exp);
  endtask

  // Monitor: every ack must match the oldest expectation; rd idles at 0
  initial begin
    logic [7:0] e;
    wait (monEn);
    forever begin
      @(negedge sys_clk);
      if (rbcp_ack) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedAck", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rbcpRd", rbcp_rd, e);
        end
      end else begin
        checkOutput("rdIdle", rbcp_rd, 0);
      end
    end
  end

  initial begin
    sys_rst   = 1'b1;
    rbcp_act  = 1'b0;
    rbcp_addr = 32'h0;
    rbcp_wd   = 8'h00;
    rbcp_we   = 1'b0;
    rbcp_re   = 1'b0;
    status_in = 32'h0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rstAck", rbcp_ack, 0);
    checkOutput("rstRd", rbcp_rd, 0);
    checkOutput("rstCtrl", ctrl_out, 8'h00);
    checkOutput("rstPulse", pulse_out, 8'h00);
    checkOutput("rstCfg", cfg_out, 32'h0);
    sys_rst = 1'b0;
    monEn   = 1'b1;

    // ID / VERSION, single and back-to-back
    rd(4'h0, 8'hA5);
    rd(4'h1, 8'h01);
    @(negedge sys_clk);
    rbcp_act = 1'b1; rbcp_re = 1'b1; rbcp_addr = BASE; expQ.push_back(8'hA5);
    @(negedge sys_clk);
    rbcp_addr = BASE + 32'h1; expQ.push_back(8'h01);
    @(negedge sys_clk);
    rbcp_act = 1'b0; rbcp_re = 1'b0;
    @(negedge sys_clk);
    #1;
    checkOutput("b2bPending", expQ.size(), 0);
    expQ.delete();

    // CTRL write/read, then reset with a coincident write
    wr(4'h2, 8'h3C);
    checkOutput("ctrlAfterWr", ctrl_out, 8'h3C);
    rd(4'h2, 8'h3C);
    @(negedge sys_clk);
    sys_rst = 1'b1; rbcp_act = 1'b1; rbcp_we = 1'b1; rbcp_addr = BASE + 32'h2; rbcp_wd = 8'h77;
    @(negedge sys_clk);
    checkOutput("ctrlRstMid", ctrl_out, 8'h00);
    checkOutput("ackRstMid", rbcp_ack, 0);
    sys_rst = 1'b0; rbcp_act = 1'b0; rbcp_we = 1'b0;
    @(negedge sys_clk);
    checkOutput("ctrlAfterRst", ctrl_out, 8'h00);

    // Status snapshot
    rd(4'h5, 8'h00);
    status_in = 32'h1122_3344;
    rd(4'h4, 8'h44);
    status_in = 32'hFFFF_FFFF;
    rd(4'h5, 8'h33);
    rd(4'h6, 8'h22);
    rd(4'h7, 8'h11);

    // Config shadow and atomic commit
    wr(4'h8, 8'hAA);
    checkOutput("cfgHold0", cfg_out, 32'h0);
    wr(4'h9, 8'hBB);
    wr(4'hA, 8'hCC);
    checkOutput("cfgHold2", cfg_out, 32'h0);
    rd(4'h8, 8'hAA);
    wr(4'hB, 8'hDD);
    checkOutput("cfgCommit", cfg_out, 32'hDDCC_BBAA);
    rd(4'hB, 8'hDD);
    wr(4'h8, 8'h11);
    checkOutput("cfgNoEarly", cfg_out, 32'hDDCC_BBAA);
    rd(4'h8, 8'h11);

    // Pulse register
    wr(4'h3, 8'h81);
    checkOutput("pulseOn", pulse_out, 8'h81);
    @(negedge sys_clk);
    checkOutput("pulseOff", pulse_out, 8'h00);
    rd(4'h3, 8'h00);

    // Misses and write+read collision
    wr(4'h2, 8'h5A);
    applyStimulus(1'b1, BASE + 32'h10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, BASE + 32'h2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, BASE + 32'h2, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, BASE + 32'h12, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, BASE + 32'hE, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("ctrlNoMissWr", ctrl_out, 8'h5A);
    applyStimulus(1'b1, BASE + 32'h2, 8'h66, 1'b1, 1'b1, 1'b1, 8'h00);
    checkOutput("ctrlWeRe", ctrl_out, 8'h66);
    wr(4'h0, 8'h00);
    rd(4'h0, 8'hA5);

`ifdef RBCP_WR_COUNTER_EN
    wr(4'hC, 8'h00);
    rd(4'hC, 8'h00);
    wr(4'h2, 8'h01);
    wr(4'h8, 8'h02);
    wr(4'h1, 8'h03);
    rd(4'hC, 8'h03);
    rd(4'hD, 8'h00);
    wr(4'hD, 8'h00);
    rd(4'hC, 8'h00);
`else
    applyStimulus(1'b1, BASE + 32'hC, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, BASE + 32'hD, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
`endif

    repeat (2) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
